// File: rtl/aes_bist_pkg.sv
// Shared types and constants for the AES-128 BIST sequencer.
// The RTL and the testbench both import this package.
package aes_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN,
        COMPARE,
        REPORT
    } bist_state_t;

    localparam logic [7:0] AES_BIST_GOLDEN = 8'hC0;

    typedef struct packed {
        logic       pass;
        logic       timeout;
        logic [7:0] sig;
    } bist_result_t;

endpackage

// File: rtl/bist_cycle_cnt.sv
// Phase cycle counter shared by the INIT, RUN and DRAIN phases of the BIST sequencer.
// hit_o flags that the current count equals the programmable terminal value.
module bist_cycle_cnt #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         hit_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/aes_bist_ctrl.sv
// BIST sequencer for the AES-128 8-bit datapath: resets the wrapper, runs the core on
// LFSR stimulus, waits for DONE, then captures and grades the MISR signature.
module aes_bist_ctrl
    import aes_bist_pkg::*;
#(
    parameter logic [7:0] GOLDEN_SIG   = AES_BIST_GOLDEN,
    parameter int         RST_CYCLES   = 2,
    parameter int         DRAIN_CYCLES = 1,
    parameter int         MAX_CYCLES   = 1023
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       done_i,
    input  logic [7:0] sig_i,
    output logic       core_rst_o,
    output logic       is_bist_o,
    output logic       en_lsfr_misr_o,
    output logic       busy_o,
    output logic       result_vld_o,
    output logic       pass_o,
    output logic       timeout_o,
    output logic [7:0] sig_cap_o
);

    // The counter must also cover the 4-bit INIT/DRAIN ranges when MAX_CYCLES is small.
    localparam int RUN_W = $clog2(MAX_CYCLES + 1);
    localparam int CW    = (RUN_W > 4) ? RUN_W : 4;

    localparam logic [CW-1:0] INIT_TERM  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] RUN_TERM   = CW'(MAX_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_TERM = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    bist_state_t  state_q, state_d;
    logic         run_tmo_q, run_tmo_d;
    bist_result_t res_q;
    logic         core_rst_q, is_bist_q, en_q, busy_q, vld_q;

    logic [CW-1:0] phase_term;
    logic [CW-1:0] phase_cnt;
    logic          phase_hit;
    logic          phase_clr;
    logic          phase_inc;

    // The counter restarts on every state change and saturates while parked in IDLE/REPORT.
    assign phase_clr = (state_d != state_q);
    assign phase_inc = (phase_cnt != '1);

    bist_cycle_cnt #(
        .W (CW)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (phase_clr),
        .inc_i  (phase_inc),
        .term_i (phase_term),
        .cnt_o  (phase_cnt),
        .hit_o  (phase_hit)
    );

    always_comb begin
        state_d    = state_q;
        run_tmo_d  = run_tmo_q;
        phase_term = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = INIT;
                    run_tmo_d = 1'b0;
                end
            end
            INIT: begin
                phase_term = INIT_TERM;
                if (phase_hit) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // DONE takes priority over the watchdog when both land in the same cycle.
                phase_term = RUN_TERM;
                if (done_i) begin
                    state_d = (DRAIN_CYCLES == 0) ? COMPARE : DRAIN;
                end else if (phase_hit) begin
                    state_d   = COMPARE;
                    run_tmo_d = 1'b1;
                end
            end
            DRAIN: begin
                phase_term = DRAIN_TERM;
                if (phase_hit) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                state_d = REPORT;
            end
            REPORT: begin
                if (start_i) begin
                    state_d   = INIT;
                    run_tmo_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            run_tmo_q  <= 1'b0;
            res_q      <= '0;
            core_rst_q <= 1'b0;
            is_bist_q  <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_tmo_q <= run_tmo_d;

            if (state_q == COMPARE) begin
                res_q.sig     <= sig_i;
                res_q.pass    <= (sig_i == GOLDEN_SIG) && !run_tmo_q;
                res_q.timeout <= run_tmo_q;
            end else if (state_d == INIT) begin
                res_q.pass    <= 1'b0;
                res_q.timeout <= 1'b0;
            end

            core_rst_q <= (state_d == INIT);
            is_bist_q  <= (state_d != IDLE);
            en_q       <= (state_d == RUN) || (state_d == DRAIN);
            busy_q     <= (state_d == INIT) || (state_d == RUN) ||
                          (state_d == DRAIN) || (state_d == COMPARE);
            vld_q      <= (state_d == REPORT);
        end
    end

    assign core_rst_o     = core_rst_q;
    assign is_bist_o      = is_bist_q;
    assign en_lsfr_misr_o = en_q;
    assign busy_o         = busy_q;
    assign result_vld_o   = vld_q;
    assign pass_o         = res_q.pass;
    assign timeout_o      = res_q.timeout;
    assign sig_cap_o      = res_q.sig;

endmodule

// File: doc/aes_bist_ctrl.md
# aes_bist_ctrl

Sequencer for the AES-128 8-bit datapath's built-in self-test. It resets the BIST wrapper, drives `is_bist` and `en_lsfr_misr` to run the core on LFSR stimulus, and waits for `DONE` while the MISR absorbs the outputs. It then captures the 8-bit signature, compares it against a golden value and reports pass, fail or timeout. It sits beside the BIST wrapper and is driven by a test-mode register or pin.

## Interface
- `GOLDEN_SIG`, default 8'hC0: expected MISR signature for a fault-free run.
- `RST_CYCLES`, default 2: cycles `core_rst` is held high before a run (1..15).
- `DRAIN_CYCLES`, default 1: cycles the enable stays high after `DONE` so the MISR absorbs the final byte (0..15).
- `MAX_CYCLES`, default 1023: run-phase watchdog limit; counter width is $clog2(MAX_CYCLES+1).
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a BIST run; ignored unless the state is IDLE or REPORT.
- `done`  in  1  wrapper `DONE`.
- `sig`  in  8  wrapper `d_out` (MISR output while `is_bist`=1).
- `core_rst`  out  1  reset to the wrapper's LFSRs, MISR and AES core.
- `is_bist`  out  1  selects LFSR stimulus and MISR output in the wrapper.
- `en_lsfr_misr`  out  1  LFSR/MISR step enable.
- `busy`  out  1  high from INIT through COMPARE.
- `result_vld`  out  1  high while in REPORT.
- `pass`  out  1  signature matched; valid only with `result_vld`.
- `timeout`  out  1  watchdog expired; valid only with `result_vld`.
- `sig_cap`  out  8  captured signature.

## Operation
- FSM states: IDLE, INIT, RUN, DRAIN, COMPARE, REPORT.
- **IDLE**: all outputs 0. On `start`, go to INIT.
- **INIT**: `core_rst`=1 and `is_bist`=1 for exactly RST_CYCLES cycles, then go to RUN. The counter is cleared on entry.
- **RUN**: `is_bist`=1 and `en_lsfr_misr`=1. The counter increments each cycle.
  - `done`=1 → DRAIN, or COMPARE if DRAIN_CYCLES=0.
  - Otherwise, when the counter reaches MAX_CYCLES → COMPARE with `timeout_r` set.
  - If `done` and the limit occur in the same cycle, `done` wins and there is no timeout.
- **DRAIN**: the enable stays high for DRAIN_CYCLES cycles, then go to COMPARE.
- **COMPARE**: `en_lsfr_misr`=0 and `is_bist` stays 1. Register `sig_cap`<=`sig`, `pass`<=(`sig`==GOLDEN_SIG) && !`timeout_r`. Go to REPORT.
- **REPORT**:
  - `result_vld`=1; `is_bist`, `pass`, `timeout` and `sig_cap` are held.
  - `start` → INIT: clears `pass`, `timeout` and `result_vld`; `sig_cap` is kept until the next COMPARE.
- `start` in INIT, RUN, DRAIN or COMPARE is ignored; there is no queuing.
- `done` outside RUN is ignored.
- `rst` at any time, including mid-run: next cycle the FSM is in IDLE and every output, including `sig_cap`, is 0. `core_rst` is not asserted by the controller during `rst`; the wrapper receives `rst` directly.
- All outputs are registered, decoded from state plus held flags. There are no combinational input-to-output paths.

## Timing
- Cycle 0: `start` sampled. Cycles 1..RST_CYCLES: `core_rst`=1.
- Cycle RST_CYCLES+1: first RUN cycle; `en_lsfr_misr`=1.
- `done` sampled high in cycle D:
  - D+1 .. D+DRAIN_CYCLES: DRAIN.
  - Next cycle: COMPARE.
  - Following cycle: `result_vld`=1.
- Default parameters: `result_vld` rises 3 cycles after the `done` sample.
- Timeout: RUN lasts exactly MAX_CYCLES cycles. COMPARE follows, then REPORT, with `timeout`=1 and `pass`=0.
- Back-to-back runs: `start` in REPORT puts INIT in the next cycle, with no IDLE cycle.

## Structure
- Package `aes_bist_pkg`:
  - state enum `bist_state_t`;
  - localparam `AES_BIST_GOLDEN` = 8'hC0, shared with the testbench;
  - `bist_result_t` struct {pass, timeout, sig[7:0]}.
- Sub-module `bist_cycle_cnt`: parameterised width, with `clr`, `inc` and `cnt`, and a `hit` compare against a programmable terminal value. One instance serves the INIT, DRAIN and RUN phases, cleared on every state change.
- Top level is FSM plus result registers, about 150-250 lines.

## Test plan
- Nominal: model `done` 40 cycles into RUN, `sig`=8'hC0 → `result_vld` 3 cycles later, `pass`=1, `timeout`=0, `sig_cap`=C0; `core_rst` high for exactly 2 cycles.
- Wrong signature: same run with `sig`=8'hC1 → `pass`=0, `timeout`=0, `sig_cap`=C1.
- Watchdog: `done` never asserts, MAX_CYCLES=20 → RUN lasts 20 cycles, then `timeout`=1 and `pass`=0 even with `sig`=C0. Variant with `done` on cycle 20 → no timeout.
- Ignored `start`: pulse `start` during RUN and DRAIN → no restart, identical result timing. `start` in REPORT → INIT next cycle and `result_vld` drops.
- Reset mid-run: `rst` in RUN cycle 5 → all outputs 0 next cycle, state IDLE; a later `start` produces a clean nominal run.
- Enable window: check `en_lsfr_misr` is high for exactly RUN plus DRAIN_CYCLES cycles, for DRAIN_CYCLES of 0, 1 and 3.
